// File: rtl/q_sys_descriptor_fetch_master.sv
// Avalon-MM master that walks a linked chain of 4-word SGDMA descriptors and hands each one to a DMA engine.
// Defining DESC_FETCH_IRQ_EN adds the irq output and the irq_clear input.
module q_sys_descriptor_fetch_master #(
  parameter int ADDR_W     = 13,
  parameter int DESC_WORDS = 4,
  parameter int MAX_DESC   = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [31:0]       desc_buf_addr,
  output logic [15:0]       desc_length,
  output logic [15:0]       desc_ctrl,
  input  logic              status_valid,
  input  logic [30:0]       status_data,
  output logic [2:0]        state_dbg
`ifdef DESC_FETCH_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_clear
`endif
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_DRAIN, CHECK, PRESENT, WAIT_STS, WB, FINISH
  } state_t;

  localparam int CW = $clog2(DESC_WORDS + 1);
  localparam int DW = $clog2(MAX_DESC + 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [CW-1:0]     issue_cnt, rx_cnt;
  logic [DW-1:0]     desc_cnt;
  logic [31:0]       next_ptr, buf_addr, ctrl_len;
  logic              own;
  logic [30:0]       sts;
  logic              stop_seen;
  logic              rx_beat, chain_end, limit_hit;

  // Read beats are only meaningful while fetching; anywhere else but IDLE they flag an error.
  assign rx_beat   = m_readdatavalid && (state == RD_ISSUE || state == RD_DRAIN);
  assign chain_end = stop_seen || stop || (next_ptr == 32'd0);
  assign limit_hit = (desc_cnt + DW'(1)) == DW'(MAX_DESC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = RD_ISSUE;
      RD_ISSUE: if (!m_waitrequest && issue_cnt == CW'(DESC_WORDS - 1)) state_nxt = RD_DRAIN;
      RD_DRAIN: if (rx_cnt == CW'(DESC_WORDS) ||
                    (rx_cnt == CW'(DESC_WORDS - 1) && m_readdatavalid)) state_nxt = CHECK;
      CHECK:    state_nxt = own ? PRESENT : FINISH;
      PRESENT:  if (desc_ready) state_nxt = WAIT_STS;
      WAIT_STS: if (status_valid) state_nxt = WB;
      WB:       if (!m_waitrequest) state_nxt = (chain_end || limit_hit) ? FINISH : RD_ISSUE;
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // desc_valid/desc_ready: a descriptor transfers on the cycle both are high; the
  // fields stay stable from the first cycle desc_valid is high until that transfer.
  always_comb begin
    busy         = (state != IDLE);
    done         = (state == FINISH);
    m_read       = (state == RD_ISSUE);
    m_write      = (state == WB);
    desc_valid   = (state == PRESENT);
    m_address    = '0;
    m_writedata  = '0;
    m_byteenable = 4'h0;
    case (state)
      RD_ISSUE: begin
        m_address    = cur_addr + ADDR_W'({issue_cnt, 2'b00});
        m_byteenable = 4'hF;
      end
      WB: begin
        m_address    = cur_addr + ADDR_W'(4 * (DESC_WORDS - 1));
        m_writedata  = {1'b0, sts};
        m_byteenable = 4'hF;
      end
      default: ;
    endcase
  end

  assign desc_buf_addr = buf_addr;
  assign desc_length   = ctrl_len[15:0];
  assign desc_ctrl     = ctrl_len[31:16];
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr  <= '0;
      issue_cnt <= '0;
      rx_cnt    <= '0;
      desc_cnt  <= '0;
      next_ptr  <= '0;
      buf_addr  <= '0;
      ctrl_len  <= '0;
      own       <= 1'b0;
      sts       <= '0;
      stop_seen <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (busy && stop) stop_seen <= 1'b1;
      if (rx_beat) begin
        case (rx_cnt)
          CW'(0):  next_ptr <= m_readdata;
          CW'(1):  buf_addr <= m_readdata;
          CW'(2):  ctrl_len <= m_readdata;
          default: own      <= m_readdata[31];
        endcase
        rx_cnt <= rx_cnt + CW'(1);
      end else if (m_readdatavalid && state != IDLE) begin
        error <= 1'b1;
      end
      case (state)
        IDLE: begin
          issue_cnt <= '0;
          rx_cnt    <= '0;
          if (start) begin
            cur_addr  <= {base_addr[ADDR_W-1:2], 2'b00};
            error     <= 1'b0;
            desc_cnt  <= '0;
            stop_seen <= 1'b0;
          end
        end
        RD_ISSUE: if (!m_waitrequest) issue_cnt <= issue_cnt + CW'(1);
        WAIT_STS: if (status_valid) sts <= status_data;
        WB: begin
          issue_cnt <= '0;
          rx_cnt    <= '0;
          if (!m_waitrequest) begin
            desc_cnt <= desc_cnt + DW'(1);
            if (!chain_end) begin
              if (limit_hit) error    <= 1'b1;
              else           cur_addr <= {next_ptr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DESC_FETCH_IRQ_EN
  logic error_d;

  // Raising wins over irq_clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq     <= 1'b0;
      error_d <= 1'b0;
    end else begin
      error_d <= error;
      if (done || (error && !error_d)) irq <= 1'b1;
      else if (irq_clear)              irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_q_sys_descriptor_fetch_master.sv
// Bench for q_sys_descriptor_fetch_master: random Avalon slave and DMA engine, chain-walk reference model, per-cycle compare.
module tb_q_sys_descriptor_fetch_master;
  localparam int ADDR_W   = 13;
  localparam int MAX_DESC = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              stop = 1'b0;
  logic              busy, done, error;
  logic [ADDR_W-1:0] m_address;
  logic              m_read, m_write;
  logic [31:0]       m_writedata;
  logic [3:0]        m_byteenable;
  logic              m_waitrequest = 1'b0;
  logic [31:0]       m_readdata = '0;
  logic              m_readdatavalid = 1'b0;
  logic              desc_valid;
  logic              desc_ready = 1'b0;
  logic [31:0]       desc_buf_addr;
  logic [15:0]       desc_length, desc_ctrl;
  logic              status_valid = 1'b0;
  logic [30:0]       status_data = '0;
  logic [2:0]        state_dbg;

  q_sys_descriptor_fetch_master #(.ADDR_W(ADDR_W), .DESC_WORDS(4), .MAX_DESC(MAX_DESC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .stop(stop),
    .busy(busy), .done(done), .error(error),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_buf_addr(desc_buf_addr), .desc_length(desc_length), .desc_ctrl(desc_ctrl),
    .status_valid(status_valid), .status_data(status_data), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]       mem  [0:2047];
  logic [31:0]       mmem [0:2047];
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_wa_q[$];
  logic [31:0]       exp_wd_q[$];
  logic [63:0]       exp_pr_q[$];
  logic [30:0]       sts_vals[$];
  bit                exp_error;

  int  wr_pct = 0, ready_pct = 100, lat_min = 1, lat_max = 1;
  bit  keep_own = 1'b0;
  logic [31:0] pend_data[$];
  int  pend_due[$];
  int  cyc = 0, sts_cnt = 0, sts_idx = 0;
  int  done_cnt = 0, done_cyc = 0, last_rd_cyc = 0, rd_acc_cnt = 0, valid_cycles = 0;
  bit  prev_done = 1'b0;
  logic [15:0] last_len = '0, last_ctrl = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: value 0x%0h", name, act);
  endtask

  // ---------------- slave, engine and compare process ----------------
  always @(negedge clk) begin
    bit hs;
    cyc++;
    m_waitrequest   = ($urandom_range(0, 99) < wr_pct);
    desc_ready      = ($urandom_range(0, 99) < ready_pct);
    m_readdatavalid = 1'b0;
    m_readdata      = $urandom;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      m_readdatavalid = 1'b1;
      m_readdata      = pend_data.pop_front();
      void'(pend_due.pop_front());
    end
    status_valid = 1'b0;
    status_data  = 31'($urandom);
    if (!reset_n) begin
      sts_cnt   = 0;
      prev_done = 1'b0;
    end else begin
      hs = desc_valid && desc_ready;
      if (sts_cnt > 0) begin
        sts_cnt--;
        if (sts_cnt == 0) begin
          status_valid = 1'b1;
          status_data  = (sts_idx < sts_vals.size()) ? sts_vals[sts_idx] : 31'h0;
          sts_idx++;
        end
      end else if (!hs && $urandom_range(0, 9) == 0) begin
        status_valid = 1'b1;
      end

      if (m_read && m_write) flag("rd_wr_overlap", {m_read, m_write});
      if (m_read || m_write) check("byteenable", m_byteenable, 4'hF);
      if (m_read && !m_waitrequest) begin
        if (exp_q.size() == 0) flag("unexpected_read", m_address);
        else check("rd_addr", m_address, exp_q.pop_front());
        pend_data.push_back(mem[m_address[12:2]]);
        pend_due.push_back(cyc + $urandom_range(lat_min, lat_max));
        last_rd_cyc = cyc;
        rd_acc_cnt++;
      end
      if (m_write && !m_waitrequest) begin
        if (exp_wa_q.size() == 0) flag("unexpected_write", m_address);
        else begin
          check("wr_addr", m_address, exp_wa_q.pop_front());
          check("wr_data", m_writedata, exp_wd_q.pop_front());
        end
        mem[m_address[12:2]] = m_writedata | (keep_own ? 32'h8000_0000 : 32'h0);
      end
      if (desc_valid) begin
        valid_cycles++;
        if (exp_pr_q.size() == 0) flag("unexpected_desc", desc_buf_addr);
        else check("desc_fields", {desc_buf_addr, desc_ctrl, desc_length}, exp_pr_q[0]);
        if (hs) begin
          if (exp_pr_q.size() > 0) void'(exp_pr_q.pop_front());
          last_len  = desc_length;
          last_ctrl = desc_ctrl;
          sts_cnt   = $urandom_range(1, 3);
        end
      end
      if (prev_done) check("busy_after_done", busy, 1'b0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = done;
    end
  end

  // ---------------- reference model ----------------
  task automatic model_walk(input logic [ADDR_W-1:0] base, input int stop_after);
    logic [ADDR_W-1:0] a, ra;
    logic [31:0] w [4];
    logic [30:0] s;
    int n;
    for (int i = 0; i < 2048; i++) mmem[i] = mem[i];
    exp_q.delete(); exp_wa_q.delete(); exp_wd_q.delete(); exp_pr_q.delete(); sts_vals.delete();
    exp_error = 1'b0;
    sts_idx = 0;
    a = base & 13'h1FFC;
    n = 0;
    forever begin
      for (int k = 0; k < 4; k++) begin
        ra = a + ADDR_W'(4 * k);
        exp_q.push_back(ra);
        w[k] = mmem[ra[12:2]];
      end
      if (!w[3][31]) break;
      exp_pr_q.push_back({w[1], w[2][31:16], w[2][15:0]});
      s = 31'($urandom);
      sts_vals.push_back(s);
      ra = a + ADDR_W'(12);
      exp_wa_q.push_back(ra);
      exp_wd_q.push_back({1'b0, s});
      mmem[ra[12:2]] = {1'b0, s} | (keep_own ? 32'h8000_0000 : 32'h0);
      n++;
      if (n >= stop_after || w[0] == 32'h0) break;
      if (n == MAX_DESC) begin
        exp_error = 1'b1;
        break;
      end
      a = w[0][12:0] & 13'h1FFC;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic put_desc(input int addr, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
    mem[addr/4] = w0; mem[addr/4 + 1] = w1; mem[addr/4 + 2] = w2; mem[addr/4 + 3] = w3;
  endtask

  task automatic run_walk(input string name, input logic [ADDR_W-1:0] base, input bit stop_first);
    int t;
    bit stopped;
    done_cnt = 0;
    valid_cycles = 0;
    stopped = 1'b0;
    @(negedge clk);
    base_addr = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_err_cleared"}, error, 1'b0);
    check({name, "_busy"}, busy, 1'b1);
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk);
      t++;
      stop = 1'b0;
      if (stop_first && !stopped && desc_valid) begin
        stop = 1'b1;
        stopped = 1'b1;
      end
    end
    stop = 1'b0;
    if (done_cnt == 0) flag({name, "_timeout"}, t);
    repeat (6) @(negedge clk);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_error"}, error, exp_error);
    check({name, "_busy_low"}, busy, 1'b0);
    check({name, "_reads_left"}, exp_q.size(), 0);
    check({name, "_desc_left"}, exp_pr_q.size(), 0);
    check({name, "_writes_left"}, exp_wa_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, len, slot0, a;
    logic [31:0] w0, w3;
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, error, m_read, m_write, m_address, m_writedata,
                            m_byteenable, desc_valid}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", {busy, done, error, m_read, m_write, desc_valid}, '0);

    // Single descriptor with literal expectations.
    put_desc(32'h100, 32'h0, 32'h2000, 32'h0001_0040, 32'h8000_0000);
    model_walk(13'h100, 1000);
    sts_vals[0] = 31'h55;
    exp_wd_q[0] = 32'h0000_0055;
    check("model_present", exp_pr_q[0], {32'h2000, 16'h0001, 16'h0040});
    check("model_wb_addr", exp_wa_q[0], 13'h10C);
    run_walk("single", 13'h100, 1'b0);
    check("single_len", last_len, 16'h0040);
    check("single_ctrl", last_ctrl, 16'h0001);
    check("single_mem_status", mem[32'h10C/4], 32'h0000_0055);

    // Chain of three under backpressure and variable latency.
    wr_pct = 50; lat_min = 1; lat_max = 3; ready_pct = 60;
    put_desc(32'h000, 32'h040, 32'h1111_0000, 32'h0002_0100, 32'h8000_0000);
    put_desc(32'h040, 32'h080, 32'h2222_0000, 32'h0003_0200, 32'h8000_0000);
    put_desc(32'h080, 32'h000, 32'h3333_0000, 32'h0004_0300, 32'h8000_0000);
    model_walk(13'h000, 1000);
    check("model_chain_len", exp_wa_q.size(), 3);
    run_walk("chain3", 13'h000, 1'b0);

    // Unowned first descriptor.
    wr_pct = 0; lat_min = 1; lat_max = 1;
    put_desc(32'h400, 32'h440, 32'h5555_0000, 32'h0000_0010, 32'h0);
    model_walk(13'h400, 1000);
    run_walk("unowned", 13'h400, 1'b0);
    check("unowned_no_valid", valid_cycles, 0);
    check("unowned_done_gap", (done_cyc - last_rd_cyc) >= 2, 1'b1);

    // Stop during the first of two.
    wr_pct = 30; lat_max = 2;
    put_desc(32'h300, 32'h340, 32'hAAAA_0000, 32'h0005_0020, 32'h8000_0000);
    put_desc(32'h340, 32'h000, 32'hBBBB_0000, 32'h0006_0030, 32'h8000_0000);
    model_walk(13'h300, 1);
    run_walk("stop", 13'h300, 1'b1);

    // Self-loop hits the chain-length limit.
    keep_own = 1'b1;
    put_desc(32'h200, 32'h200, 32'hCCCC_0000, 32'h0007_0040, 32'h8000_0000);
    model_walk(13'h200, 1000);
    check("model_loop_error", exp_error, 1'b1);
    run_walk("selfloop", 13'h200, 1'b0);
    keep_own = 1'b0;

    // A fresh start clears the sticky error.
    put_desc(32'h100, 32'h0, 32'h2000, 32'h0001_0040, 32'h8000_0000);
    model_walk(13'h100, 1000);
    run_walk("after_loop", 13'h100, 1'b0);

    // Reset with two reads outstanding.
    wr_pct = 0; lat_min = 3; lat_max = 3; ready_pct = 100;
    put_desc(32'h500, 32'h0, 32'h7777_0000, 32'h0008_0050, 32'h8000_0000);
    model_walk(13'h500, 1000);
    rd_acc_cnt = 0;
    @(negedge clk);
    base_addr = 13'h500;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (rd_acc_cnt < 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (rd_acc_cnt < 2) flag("rst_wait_timeout", t);
    #2 reset_n = 1'b0;
    #1;
    check("rst_outputs", {busy, done, error, m_read, m_write, m_address, m_writedata,
                          m_byteenable, desc_valid, desc_buf_addr, desc_length, desc_ctrl}, '0);
    check("rst_outstanding", pend_due.size(), 2);
    exp_q.delete(); exp_wa_q.delete(); exp_wd_q.delete(); exp_pr_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_late_beats_drained", pend_due.size(), 0);
    check("rst_no_error", error, 1'b0);
    check("rst_idle", busy, 1'b0);
    lat_min = 1; lat_max = 3;
    model_walk(13'h500, 1000);
    run_walk("after_reset", 13'h500, 1'b0);

    // Randomized chains.
    for (int r = 0; r < 8; r++) begin
      wr_pct    = $urandom_range(0, 60);
      ready_pct = $urandom_range(30, 100);
      len       = $urandom_range(1, 5);
      slot0     = $urandom_range(0, 400);
      for (int i = 0; i < len; i++) begin
        a  = (1 + (slot0 + 7 * i) % 511) * 16;
        w0 = (i == len - 1) ? 32'h0 : 32'((1 + (slot0 + 7 * (i + 1)) % 511) * 16 + $urandom_range(0, 3));
        w3 = ($urandom_range(0, 9) == 0) ? 32'h0 : 32'h8000_0000 | 32'($urandom_range(0, 255));
        put_desc(a, w0, $urandom, $urandom, w3);
      end
      a = (1 + slot0 % 511) * 16 + $urandom_range(0, 3);
      model_walk(ADDR_W'(a), 1000);
      run_walk("random", ADDR_W'(a), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
